// File: rtl/card_display_bank.sv
// Multi-slot card display bank: stores dealt card codes, drives one 7-segment pattern per slot,
// tracks occupancy/count/baccarat score, and clears the hand with a one-slot-per-cycle sweep.
// Optional new-card blink is compiled in with `define CARD_BLINK_EN.
module card_display_bank #(
    parameter int NUM_SLOTS = 6,
    parameter int SLOT_W    = 3,
    parameter int BLINK_DIV = 8
) (
    input  logic                   slow_clock,
    input  logic                   resetb,
    input  logic                   load,
    input  logic [SLOT_W-1:0]      slot,
    input  logic [3:0]             card,
    input  logic                   clear,
    output logic                   busy,
    output logic                   err,
    output logic [7*NUM_SLOTS-1:0] seg_out,
    output logic [NUM_SLOTS-1:0]   valid_mask,
    output logic [SLOT_W:0]        count,
    output logic [3:0]             score
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [SLOT_W-1:0] LAST_IDX    = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W:0]   NUM_SLOTS_W = (SLOT_W + 1)'(NUM_SLOTS);

    if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || (1 << SLOT_W) < NUM_SLOTS || BLINK_DIV < 1) begin : g_bad_params
        $error("card_display_bank: illegal parameter combination");
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] c);
        case (c)
            4'd1:    return 7'b1110111;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            4'd10:   return 7'b1111110;
            4'd11:   return 7'b0111100;
            4'd12:   return 7'b1110011;
            4'd13:   return 7'b0110111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Tens and court cards count zero in baccarat.
    function automatic logic [3:0] card_value(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    state_t            state_reg, state_next;
    logic [SLOT_W-1:0] idx_reg, idx_next;
    logic [3:0]        slots_reg [NUM_SLOTS];
    logic              busy_reg, busy_next;
    logic              err_reg, err_next;
    logic [3:0]        score_reg, score_next;
    logic [SLOT_W:0]   count_reg, count_next;
    logic              accept;
    logic [6:0]        sum;
    logic [7*NUM_SLOTS-1:0] seg_plain;

    // State register
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
            score_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
            err_reg   <= err_next;
            score_reg <= score_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + SLOT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / request-arbitration logic; clear beats a simultaneous load.
    always_comb begin
        accept    = load && (state_reg == IDLE) && !clear
                    && ({1'b0, slot} < NUM_SLOTS_W) && (card <= 4'd13);
        err_next  = load && !accept;
        busy_next = (state_next == CLEAR);
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_SLOTS; i++) slots_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (state_reg == CLEAR && idx_reg == SLOT_W'(i))
                    slots_reg[i] <= '0;
                else if (accept && slot == SLOT_W'(i))
                    slots_reg[i] <= card;
            end
        end
    end

    always_comb begin
        sum        = '0;
        count_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sum        = sum + 7'(card_value(slots_reg[i]));
            count_next = count_next + {{SLOT_W{1'b0}}, valid_mask[i]};
        end
        score_next = 4'(sum % 7'd10);
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign valid_mask[gi]       = (slots_reg[gi] != 4'd0);
        assign seg_plain[7*gi +: 7] = seg_decode(slots_reg[gi]);
    end

`ifdef CARD_BLINK_EN
    localparam int BLINK_CW = $clog2(BLINK_DIV + 1);

    logic [BLINK_CW-1:0] blink_cnt_reg;
    logic                phase_reg;
    logic                new_valid_reg;
    logic [SLOT_W-1:0]   new_slot_reg;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            new_valid_reg <= 1'b0;
            new_slot_reg  <= '0;
        end else begin
            if (blink_cnt_reg == BLINK_CW'(BLINK_DIV - 1)) begin
                blink_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BLINK_CW'(1);
            end
            // Any accepted load moves or drops the mark; an empty write leaves nothing to blink.
            if (accept) begin
                new_valid_reg <= (card != 4'd0);
                new_slot_reg  <= slot;
            end else if (state_reg == IDLE && clear) begin
                new_valid_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_blink
        assign seg_out[7*gi +: 7] =
            (phase_reg && new_valid_reg && new_slot_reg == SLOT_W'(gi)) ? 7'b0000000 : seg_plain[7*gi +: 7];
    end
`else
    assign seg_out = seg_plain;
`endif

    assign busy  = busy_reg;
    assign err   = err_reg;
    assign score = score_reg;
    assign count = count_reg;

endmodule

// File: tb/tb_card_display_bank.sv
// Bench for card_display_bank: directed vector table from the test plan, a mid-sweep reset,
// then randomized traffic checked against a slot-array reference model.
module tb_card_display_bank;

    localparam int N = 6;
    localparam int W = 3;

    logic           slow_clock = 1'b0;
    logic           resetb;
    logic           load;
    logic [W-1:0]   slot;
    logic [3:0]     card;
    logic           clear;
    logic           busy;
    logic           err;
    logic [7*N-1:0] seg_out;
    logic [N-1:0]   valid_mask;
    logic [W:0]     count;
    logic [3:0]     score;

    int n_pass  = 0;
    int n_total = 0;

    card_display_bank #(.NUM_SLOTS(N), .SLOT_W(W), .BLINK_DIV(4)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .load       (load),
        .slot       (slot),
        .card       (card),
        .clear      (clear),
        .busy       (busy),
        .err        (err),
        .seg_out    (seg_out),
        .valid_mask (valid_mask),
        .count      (count),
        .score      (score)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            1: return 7'b1110111;   2: return 7'b1101101;   3: return 7'b1111001;
            4: return 7'b0110011;   5: return 7'b1011011;   6: return 7'b1011111;
            7: return 7'b1110000;   8: return 7'b1111111;   9: return 7'b1111011;
            10: return 7'b1111110;  11: return 7'b0111100;  12: return 7'b1110011;
            13: return 7'b0110111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Reference model: hand contents plus remaining sweep length.
    int   m_slots [N];
    int   m_sweep, m_score, m_count;
    logic m_busy, m_err;

    task automatic model_reset();
        foreach (m_slots[i]) m_slots[i] = 0;
        m_sweep = 0; m_score = 0; m_count = 0; m_busy = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic ld, input int sl, input int cd, input logic cl);
        int   total = 0;
        int   cnt = 0;
        logic rej = 0;
        foreach (m_slots[i]) begin
            total += (m_slots[i] >= 1 && m_slots[i] <= 9) ? m_slots[i] : 0;
            cnt   += (m_slots[i] != 0) ? 1 : 0;
        end
        m_score = total % 10;
        m_count = cnt;
        if (m_sweep > 0) begin
            m_slots[N - m_sweep] = 0;
            m_sweep--;
            rej = ld;
        end else if (cl) begin
            m_sweep = N;
            rej = ld;
        end else if (ld) begin
            if (sl < N && cd <= 13) m_slots[sl] = cd;
            else rej = 1;
        end
        m_busy = (m_sweep > 0);
        m_err  = rej;
    endtask

    typedef struct {
        logic       ld;
        int         sl;
        int         cd;
        logic       cl;
        logic [5:0] mask;
        int         cnt;
        int         scr;
        logic       bsy;
        logic       er;
        int         seg_slot;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [20];

    initial begin
        logic [7*N-1:0] exp_seg;
        logic [6:0]     seg_field;
        logic [W:0]     exp_cnt;
        logic [3:0]     exp_scr;

        vecs[0]  = '{1'b1, 0, 9,  1'b0, 6'b000001, 0, 0, 1'b0, 1'b0, 0, 7'b1111011};
        vecs[1]  = '{1'b1, 1, 5,  1'b0, 6'b000011, 1, 9, 1'b0, 1'b0, 1, 7'b1011011};
        vecs[2]  = '{1'b0, 0, 0,  1'b0, 6'b000011, 2, 4, 1'b0, 1'b0, 0, 7'b1111011};
        vecs[3]  = '{1'b1, 2, 13, 1'b0, 6'b000111, 2, 4, 1'b0, 1'b0, 2, 7'b0110111};
        vecs[4]  = '{1'b1, 2, 1,  1'b0, 6'b000111, 3, 4, 1'b0, 1'b0, 2, 7'b1110111};
        vecs[5]  = '{1'b0, 0, 0,  1'b0, 6'b000111, 3, 5, 1'b0, 1'b0, 2, 7'b1110111};
        vecs[6]  = '{1'b1, 3, 14, 1'b0, 6'b000111, 3, 5, 1'b0, 1'b1, 3, 7'b0000000};
        vecs[7]  = '{1'b1, 6, 2,  1'b0, 6'b000111, 3, 5, 1'b0, 1'b1, 1, 7'b1011011};
        vecs[8]  = '{1'b0, 0, 0,  1'b0, 6'b000111, 3, 5, 1'b0, 1'b0, 0, 7'b1111011};
        vecs[9]  = '{1'b0, 0, 0,  1'b1, 6'b000111, 3, 5, 1'b1, 1'b0, 0, 7'b1111011};
        vecs[10] = '{1'b1, 4, 3,  1'b0, 6'b000110, 3, 5, 1'b1, 1'b1, 4, 7'b0000000};
        vecs[11] = '{1'b0, 0, 0,  1'b0, 6'b000100, 2, 6, 1'b1, 1'b0, 1, 7'b0000000};
        vecs[12] = '{1'b0, 0, 0,  1'b0, 6'b000000, 1, 1, 1'b1, 1'b0, 2, 7'b0000000};
        vecs[13] = '{1'b0, 0, 0,  1'b0, 6'b000000, 0, 0, 1'b1, 1'b0, 0, 7'b0000000};
        vecs[14] = '{1'b0, 0, 0,  1'b0, 6'b000000, 0, 0, 1'b1, 1'b0, 0, 7'b0000000};
        vecs[15] = '{1'b0, 0, 0,  1'b0, 6'b000000, 0, 0, 1'b0, 1'b0, 0, 7'b0000000};
        vecs[16] = '{1'b1, 5, 8,  1'b0, 6'b100000, 0, 0, 1'b0, 1'b0, 5, 7'b1111111};
        vecs[17] = '{1'b1, 0, 8,  1'b1, 6'b100000, 1, 8, 1'b1, 1'b1, 0, 7'b0000000};
        vecs[18] = '{1'b0, 0, 0,  1'b0, 6'b100000, 1, 8, 1'b1, 1'b0, 5, 7'b1111111};
        vecs[19] = '{1'b0, 0, 0,  1'b0, 6'b100000, 1, 8, 1'b1, 1'b0, 5, 7'b1111111};

        resetb = 1'b0; load = 1'b0; slot = '0; card = '0; clear = 1'b0;
        #12;
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_err",   64'(err), 64'd0);
        check("reset_seg",   64'(seg_out), 64'd0);
        check("reset_mask",  64'(valid_mask), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_score", 64'(score), 64'd0);
        #10 resetb = 1'b1;
        tick();

        for (int v = 0; v < 20; v++) begin
            load = vecs[v].ld; slot = W'(vecs[v].sl); card = 4'(vecs[v].cd); clear = vecs[v].cl;
            tick();
            seg_field = seg_out[7*vecs[v].seg_slot +: 7];
            $display("vec %0d: load=%0b slot=%0d card=%0d clear=%0b -> busy=%0b err=%0b mask=%b count=%0d score=%0d",
                     v, vecs[v].ld, vecs[v].sl, vecs[v].cd, vecs[v].cl, busy, err, valid_mask, count, score);
            check($sformatf("vec%0d_mask", v),  64'(valid_mask), 64'(vecs[v].mask));
            check($sformatf("vec%0d_count", v), 64'(count), 64'(vecs[v].cnt));
            check($sformatf("vec%0d_score", v), 64'(score), 64'(vecs[v].scr));
            check($sformatf("vec%0d_busy", v),  64'(busy), 64'(vecs[v].bsy));
            check($sformatf("vec%0d_err", v),   64'(err), 64'(vecs[v].er));
            check($sformatf("vec%0d_seg", v),   64'(seg_field), 64'(vecs[v].seg));
        end

        // Asynchronous reset three cycles into a sweep must abort it without a clock edge.
        load = 1'b0; clear = 1'b0;
        #2 resetb = 1'b0;
        #1;
        $display("midsweep reset: busy=%0b err=%0b mask=%b count=%0d score=%0d", busy, err, valid_mask, count, score);
        check("abort_busy",  64'(busy), 64'd0);
        check("abort_seg",   64'(seg_out), 64'd0);
        check("abort_mask",  64'(valid_mask), 64'd0);
        check("abort_count", 64'(count), 64'd0);
        check("abort_score", 64'(score), 64'd0);
        #2 resetb = 1'b1;
        tick();
        tick();
        check("abort_no_resume", 64'(busy), 64'd0);

        model_reset();
        for (int c = 0; c < 1500; c++) begin
            logic ld, cl;
            int   sl, cd;
            ld = ($urandom_range(0, 99) < 60);
            cl = ($urandom_range(0, 99) < 4);
            sl = $urandom_range(0, 7);
            cd = $urandom_range(0, 15);
            load = ld; clear = cl; slot = W'(sl); card = 4'(cd);
            model_edge(ld, sl, cd, cl);
            tick();
            exp_seg = '0;
            for (int i = 0; i < N; i++) exp_seg[7*i +: 7] = seg_of(m_slots[i]);
            exp_cnt = (W + 1)'(m_count);
            exp_scr = 4'(m_score);
            $display("rnd %0d: load=%0b slot=%0d card=%0d clear=%0b -> busy=%0b err=%0b mask=%b count=%0d score=%0d",
                     c, ld, sl, cd, cl, busy, err, valid_mask, count, score);
            check("rnd_seg",   64'(seg_out), 64'(exp_seg));
            check("rnd_mask",  64'(valid_mask), 64'(valid_mask_of_model()));
            check("rnd_count", 64'(count), 64'(exp_cnt));
            check("rnd_score", 64'(score), 64'(exp_scr));
            check("rnd_busy",  64'(busy), 64'(m_busy));
            check("rnd_err",   64'(err), 64'(m_err));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic logic [N-1:0] valid_mask_of_model();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = (m_slots[i] != 0);
        return m;
    endfunction

endmodule

// File: doc/card_display_bank.md
Name: card_display_bank

Overview:
- Parametrised successor to the single-card 7-segment decoder.
- Holds up to NUM_SLOTS dealt card codes in registers and drives one 7-segment pattern per slot.
- Maintains an occupancy mask, a slot count and a running baccarat score (sum of card values mod 10).
- Sits between the deal datapath and the HEX displays. A multi-cycle clear sweep resets the hand between rounds.

Parameters:
- NUM_SLOTS, 6, number of card slots (2..8).
- SLOT_W, 3, width of the slot index; must satisfy 2^SLOT_W >= NUM_SLOTS.
- BLINK_DIV, 8, half-period in cycles of the new-card blink (used only with BLINK_EN).

Ports:
- slow_clock  in  1  sole clock, rising edge.
- resetb  in  1  asynchronous active-low reset.
- load  in  1  write request: store card into slot.
- slot  in  SLOT_W  target slot index for load.
- card  in  4  card code: 0=empty, 1=A, 2..10, 11=J, 12=Q, 13=K, 14/15 illegal.
- clear  in  1  request a clear sweep of all slots.
- busy  out  1  high while the clear sweep runs.
- err  out  1  one-cycle pulse on any rejected request.
- seg_out  out  7*NUM_SLOTS  active-high segment patterns; slot i occupies bits [7i+6:7i].
- valid_mask  out  NUM_SLOTS  bit i set when slot i holds a nonzero code.
- count  out  SLOT_W+1  number of set bits in valid_mask.
- score  out  4  (sum of values of all slots) mod 10.

Behaviour:
- Reset (resetb low, asynchronous) sets all slots to 0, busy=0, err=0, score=0 and count=0. seg_out is all zeros and valid_mask is 0.
- Segment patterns, decided:
  - 0 -> 0000000; 1 -> 1110111; 2 -> 1101101; 3 -> 1111001; 4 -> 0110011
  - 5 -> 1011011; 6 -> 1011111; 7 -> 1110000; 8 -> 1111111; 9 -> 1111011
  - 10 -> 1111110; 11 -> 0111100; 12 -> 1110011; 13 -> 0110111
- seg_out and valid_mask are combinational decodes of the slot registers. They change right after the accepting edge.
- Card values: A=1; 2..9 face value; 10, J, Q and K = 0; empty = 0.
- score and count are registered. They reflect the slot contents one edge after the slot-changing edge.
- FSM states:
  - IDLE -> CLEAR when clear=1 is sampled in IDLE.
  - CLEAR sweeps an index from 0 to NUM_SLOTS-1, writing 0 to one slot per cycle.
  - After clearing slot NUM_SLOTS-1, the FSM returns to IDLE.
- busy is registered and is high for exactly NUM_SLOTS cycles, starting the edge after clear is sampled.
- Load accepted (IDLE, clear=0, slot < NUM_SLOTS, card <= 13): the slot is overwritten at that edge. Writing 0 empties the slot.
- Load rejected, slot unchanged, err=1 for the next cycle, in these cases:
  - slot >= NUM_SLOTS
  - card is 14 or 15
  - load while busy
  - load and clear in the same IDLE cycle (clear wins)
- clear while busy is ignored, with no err.
- err is registered and lasts one cycle per rejected edge. Back-to-back rejects hold it high.
- Reset asserted mid-sweep aborts the sweep immediately; the block returns to reset state.

Optional Feature:
- Macro: CARD_BLINK_EN.
- Defined:
  - The most recently accepted nonzero load marks that slot as "new".
  - A free-running counter toggles a phase bit every BLINK_DIV cycles.
  - The new slot's seg_out is forced to 0000000 while the phase bit = 1.
  - The next accepted load, a clear sweep or reset cancels the "new" mark. Reset also zeroes the phase.
  - valid_mask, count and score are unaffected.
- Not defined: no counter, no blink logic; seg_out is always the pure decode. BLINK_DIV is ignored.

Test Plan:
- Reset, then load slot0=9 and slot1=5 on consecutive edges:
  - seg_out[6:0]=1111011 and seg_out[13:7]=1011011.
  - valid_mask=000011, count=2, score=4 one edge after the second load.
- Load slot2=13, then slot2=1 (overwrite):
  - seg_out[20:14] goes 0110111 then 1110111.
  - score goes 4 then 5; count stays 3.
- Load slot3 card=14, then slot=6 card=2 (NUM_SLOTS=6): err pulses each cycle, slots unchanged, score=5.
- Assert clear for one cycle, and also assert load on the following cycle:
  - busy is high 6 cycles.
  - The load is rejected with err.
  - Afterwards seg_out=0, valid_mask=0, count=0, score=0.
- Start the clear sweep, drop resetb after 3 busy cycles: busy=0 immediately; all outputs at reset values.
- With CARD_BLINK_EN and BLINK_DIV=4, load slot0=7:
  - seg_out[6:0] alternates 1110000 / 0000000 every 4 cycles.
  - Loading slot1=2 restores slot0 steady; slot1 now blinks.
